// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_bus_arbiter                                              |
// | Description : Round-robin arbiter that shares one single-beat downstream   |
// |               memory port between instruction fetch (port 0) and data      |
// |               (port 1). One outstanding transaction at a time.             |
// |               Optional per-port performance counters: ARB_PERF_CNT_EN.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int CNT_W   = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_strobe,
  output logic [NUM_REQ-1:0]          resp_data_ok,
  output logic [DATA_W-1:0]           resp_data,
  output logic                        mem_valid,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_write,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [DATA_W/8-1:0]         mem_strobe,
  input  logic                        mem_data_ok,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [NUM_REQ*CNT_W-1:0]    grant_cnt,
  output logic [NUM_REQ*CNT_W-1:0]    wait_cnt
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Pointer starts at the last port so port 0 wins the first tie.
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   grant;
  logic               aborted;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W:0]     rr_sum;

  logic [ADDR_W-1:0]  addr_arr   [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr  [NUM_REQ];
  logic [STRB_W-1:0]  strobe_arr [NUM_REQ];

  // Split the flat request buses into per-port fields.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]   = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i]  = req_wdata[i*DATA_W +: DATA_W];
    assign strobe_arr[i] = req_strobe[i*STRB_W +: STRB_W];
  end

  // Round-robin search starting at the port after the last grant.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_sum    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rr_sum = {1'b0, last_grant} + (IDX_W+1)'(i + 1);
      if (rr_sum >= (IDX_W+1)'(NUM_REQ)) begin
        rr_sum = rr_sum - (IDX_W+1)'(NUM_REQ);
      end
      if (!win_found && req_valid[rr_sum[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = rr_sum[IDX_W-1:0];
      end
    end
  end

  // Transaction FSM; every downstream and response output is registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      last_grant   <= LAST_RST;
      grant        <= '0;
      aborted      <= 1'b0;
      mem_valid    <= 1'b0;
      mem_addr     <= '0;
      mem_write    <= 1'b0;
      mem_wdata    <= '0;
      mem_strobe   <= '0;
      resp_data_ok <= '0;
      resp_data    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          resp_data_ok <= '0;
          if (win_found) begin
            grant      <= win_idx;
            mem_addr   <= addr_arr[win_idx];
            mem_write  <= req_write[win_idx];
            mem_wdata  <= wdata_arr[win_idx];
            mem_strobe <= strobe_arr[win_idx];
            mem_valid  <= 1'b1;
            aborted    <= 1'b0;
            state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // A requester that lets go of valid mid-transaction is not answered.
          if (!req_valid[grant]) begin
            aborted <= 1'b1;
          end
          if (mem_data_ok) begin
            mem_valid <= 1'b0;
            state     <= ST_RESP;
            if (req_valid[grant] && !aborted) begin
              resp_data_ok <= NUM_REQ'(1) << grant;
              resp_data    <= mem_rdata;
            end
          end
        end
        ST_RESP: begin
          resp_data_ok <= '0;
          last_grant   <= grant;
          state        <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic             holder_valid;
  logic [IDX_W-1:0] holder_idx;

  // Grant holder: the arbitration winner while idle, the latched grant otherwise.
  always_comb begin
    holder_valid = 1'b1;
    holder_idx   = grant;
    if (state == ST_IDLE) begin
      holder_valid = win_found;
      holder_idx   = win_idx;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
    logic [CNT_W-1:0] grant_q;
    logic [CNT_W-1:0] wait_q;

    // Free-running wrapping counters of completions and stalled cycles.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        grant_q <= '0;
        wait_q  <= '0;
      end else begin
        if (resp_data_ok[i]) begin
          grant_q <= grant_q + 1'b1;
        end
        if (req_valid[i] && !(holder_valid && (holder_idx == IDX_W'(i)))) begin
          wait_q <= wait_q + 1'b1;
        end
      end
    end

    assign grant_cnt[i*CNT_W +: CNT_W] = grant_q;
    assign wait_cnt[i*CNT_W +: CNT_W]  = wait_q;
  end
`else
  assign grant_cnt = '0;
  assign wait_cnt  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_bus_arbiter                                           |
// | Description : Directed self-checking bench for mem_bus_arbiter with a      |
// |               fixed-latency memory responder advanced once per cycle.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_bus_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid;
  logic [127:0] req_addr;
  logic [1:0]   req_write;
  logic [127:0] req_wdata;
  logic [15:0]  req_strobe;
  logic [1:0]   resp_data_ok;
  logic [63:0]  resp_data;
  logic         mem_valid;
  logic [63:0]  mem_addr;
  logic         mem_write;
  logic [63:0]  mem_wdata;
  logic [7:0]   mem_strobe;
  logic         mem_data_ok;
  logic [63:0]  mem_rdata;
  logic [63:0]  grant_cnt;
  logic [63:0]  wait_cnt;

  int           checks = 0;
  int           errors = 0;
  int           mem_lat;
  int           mem_cnt;
  logic [63:0]  rd_val;

  mem_bus_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_write    (req_write),
    .req_wdata    (req_wdata),
    .req_strobe   (req_strobe),
    .resp_data_ok (resp_data_ok),
    .resp_data    (resp_data),
    .mem_valid    (mem_valid),
    .mem_addr     (mem_addr),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
    .mem_strobe   (mem_strobe),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata),
    .grant_cnt    (grant_cnt),
    .wait_cnt     (wait_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to the next falling edge, then step the memory model: it answers
  // mem_data_ok for one cycle once mem_valid has been seen mem_lat times.
  task automatic tick();
    @(negedge clk);
    if (mem_data_ok) begin
      mem_data_ok = 1'b0;
      mem_cnt     = 0;
    end else if (mem_valid) begin
      mem_cnt++;
      if (mem_cnt == mem_lat) begin
        mem_data_ok = 1'b1;
        mem_rdata   = rd_val;
      end
    end else begin
      mem_cnt = 0;
    end
  endtask

  task automatic set_port(input int p, input logic [63:0] addr, input logic wr,
                          input logic [63:0] wd, input logic [7:0] st);
    req_addr[p*64 +: 64]  = addr;
    req_write[p]          = wr;
    req_wdata[p*64 +: 64] = wd;
    req_strobe[p*8 +: 8]  = st;
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = 2'b00;
    req_addr    = '0;
    req_write   = '0;
    req_wdata   = '0;
    req_strobe  = '0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    mem_cnt     = 0;
    mem_lat     = 2;
    rd_val      = 64'h55;

    // Reset state, with both ports already requesting.
    tick();
    set_port(0, 64'h1000, 1'b0, 64'h0, 8'h00);
    set_port(1, 64'h2000, 1'b0, 64'h0, 8'h00);
    req_valid = 2'b11;
    tick();
    check("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
    check("rst_resp_ok", {62'd0, resp_data_ok}, 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    reset = 1'b0;

    // Contention: 4-cycle grant period with memory latency 2 -> 0,1,0,1.
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c % 4 == 1) begin
        check("cont_mem_valid", {63'd0, mem_valid}, 64'd1);
        check("cont_mem_addr", mem_addr, (((c - 1) / 4) % 2 == 1) ? 64'h2000 : 64'h1000);
      end else if (c % 4 == 3) begin
        check("cont_resp_ok", {62'd0, resp_data_ok}, (((c - 1) / 4) % 2 == 1) ? 64'd2 : 64'd1);
        check("cont_resp_data", resp_data, 64'h55);
      end else if (c % 4 == 0) begin
        check("cont_idle_valid", {63'd0, mem_valid}, 64'd0);
      end
    end
    req_valid = 2'b00;
    tick();
`ifdef ARB_PERF_CNT_EN
    check("perf_grant0", grant_cnt[31:0], 64'd2);
    check("perf_grant1", grant_cnt[63:32], 64'd2);
    check("perf_wait1", wait_cnt[63:32], 64'd8);
`endif

    // Abort: port 0 drops valid after grant; port 1 is pending.
    mem_lat = 3;
    rd_val  = 64'h77;
    set_port(0, 64'h3000, 1'b0, 64'h0, 8'h00);
    set_port(1, 64'h4000, 1'b0, 64'h0, 8'h00);
    req_valid = 2'b11;
    tick();
    check("abort_mem_addr", mem_addr, 64'h3000);
    req_valid = 2'b10;
    tick();
    tick();
    check("abort_still_busy", {63'd0, mem_valid}, 64'd1);
    tick();
    check("abort_resp_ok", {62'd0, resp_data_ok}, 64'd0);
    check("abort_mem_done", {63'd0, mem_valid}, 64'd0);
    check("abort_resp_hold", resp_data, 64'h55);
    tick();
    tick();
    check("abort_next_valid", {63'd0, mem_valid}, 64'd1);
    check("abort_next_addr", mem_addr, 64'h4000);
    tick();
    tick();
    tick();
    check("abort_next_resp", {62'd0, resp_data_ok}, 64'd2);
    check("abort_next_data", resp_data, 64'h77);
    req_valid = 2'b00;
    tick();

    // Write from port 1; requester changes its fields mid-transaction.
    rd_val = 64'h0;
    set_port(1, 64'h5000, 1'b1, 64'hDEAD_BEEF, 8'h0F);
    req_valid = 2'b10;
    tick();
    check("wr_mem_write", {63'd0, mem_write}, 64'd1);
    check("wr_mem_wdata", mem_wdata, 64'hDEAD_BEEF);
    check("wr_mem_strobe", {56'd0, mem_strobe}, 64'h0F);
    set_port(1, 64'h6000, 1'b1, 64'h1234_5678, 8'hFF);
    tick();
    check("wr_wdata_held", mem_wdata, 64'hDEAD_BEEF);
    check("wr_addr_held", mem_addr, 64'h5000);
    check("wr_strobe_held", {56'd0, mem_strobe}, 64'h0F);
    tick();
    tick();
    check("wr_resp_ok", {62'd0, resp_data_ok}, 64'd2);
    req_valid = 2'b00;
    set_port(1, 64'h0, 1'b0, 64'h0, 8'h00);
    tick();
    check("wr_resp_clear", {62'd0, resp_data_ok}, 64'd0);

    // Single read on port 0, latency 3, data 0x13.
    rd_val = 64'h13;
    set_port(0, 64'h8000_0000, 1'b0, 64'h0, 8'h00);
    req_valid = 2'b01;
    tick();
    check("rd_mem_valid", {63'd0, mem_valid}, 64'd1);
    check("rd_mem_addr", mem_addr, 64'h8000_0000);
    check("rd_mem_write", {63'd0, mem_write}, 64'd0);
    tick();
    tick();
    check("rd_resp_early", {62'd0, resp_data_ok}, 64'd0);
    tick();
    check("rd_resp_ok", {62'd0, resp_data_ok}, 64'd1);
    check("rd_resp_data", resp_data, 64'h13);
    check("rd_valid_drop", {63'd0, mem_valid}, 64'd0);
    req_valid = 2'b00;
    tick();
    check("rd_pulse_width", {62'd0, resp_data_ok}, 64'd0);
    check("rd_data_hold", resp_data, 64'h13);

    // Spurious mem_data_ok while idle must be ignored.
    mem_data_ok = 1'b1;
    tick();
    check("spur_mem_valid", {63'd0, mem_valid}, 64'd0);
    tick();
    check("spur_resp_ok", {62'd0, resp_data_ok}, 64'd0);

    // Reset during BUSY on port 1, then a tie that port 0 must win.
    rd_val = 64'h99;
    set_port(1, 64'h7000, 1'b0, 64'h0, 8'h00);
    req_valid = 2'b10;
    tick();
    check("rstb_mem_addr", mem_addr, 64'h7000);
    reset = 1'b1;
    #1;
    check("rstb_mem_valid", {63'd0, mem_valid}, 64'd0);
    check("rstb_resp_ok", {62'd0, resp_data_ok}, 64'd0);
    check("rstb_mem_addr0", mem_addr, 64'd0);
    set_port(0, 64'h9000, 1'b0, 64'h0, 8'h00);
    req_valid = 2'b11;
    tick();
    reset = 1'b0;
    tick();
    check("rstb_tie_valid", {63'd0, mem_valid}, 64'd1);
    check("rstb_tie_addr", mem_addr, 64'h9000);
    tick();
    tick();
    check("rstb_no_resp", {62'd0, resp_data_ok}, 64'd0);
    tick();
    check("rstb_resp_ok", {62'd0, resp_data_ok}, 64'd1);
    check("rstb_resp_data", resp_data, 64'h99);
    req_valid = 2'b00;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single downstream memory port between the instruction-fetch bus (port 0) and the data bus (port 1).
- Sits between fetch/memory stages and the cache/memory interface.
- Single-beat requests, one outstanding transaction at a time, round-robin arbitration.
- Requester-side handshake matches the fetch unit's: hold valid until a one-cycle data_ok pulse.

Parameters:
- NUM_REQ, 2, number of requester ports; port 0 = ifetch, port 1 = data.
- ADDR_W, 64, address width.
- DATA_W, 64, data width; strobe width is DATA_W/8.
- CNT_W, 32, width of performance counters (optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  per-port request valid
- req_addr  in  NUM_REQ*ADDR_W  per-port address
- req_write  in  NUM_REQ  per-port write flag
- req_wdata  in  NUM_REQ*DATA_W  per-port write data
- req_strobe  in  NUM_REQ*DATA_W/8  per-port byte strobes
- resp_data_ok  out  NUM_REQ  one-cycle completion pulse per port
- resp_data  out  DATA_W  read data, shared, valid with resp_data_ok
- mem_valid  out  1  downstream request valid
- mem_addr  out  ADDR_W  downstream address
- mem_write  out  1  downstream write flag
- mem_wdata  out  DATA_W  downstream write data
- mem_strobe  out  DATA_W/8  downstream strobes
- mem_data_ok  in  1  downstream completion pulse, one cycle
- mem_rdata  in  DATA_W  downstream read data, valid with mem_data_ok
- grant_cnt  out  NUM_REQ*CNT_W  per-port completed-grant counters (optional feature)
- wait_cnt  out  NUM_REQ*CNT_W  per-port stalled-cycle counters (optional feature)

Behaviour:
- Reset values: all outputs 0; state IDLE; last-grant pointer = NUM_REQ-1, so port 0 wins the first tie.
- FSM IDLE:
  - If any req_valid is set, pick a winner round-robin, searching from (last+1) mod NUM_REQ.
  - Latch the winner's addr/write/wdata/strobe into registers, record grant index g, go to BUSY.
  - mem_valid rises the next cycle.
- FSM BUSY:
  - mem_valid=1; mem_* driven only from the latched registers, so requester changes after grant have no effect downstream.
  - On mem_data_ok: mem_valid drops the same cycle (combinational from state+mem_data_ok is forbidden; mem_valid is a registered output cleared on the next edge). Go to RESP; capture mem_rdata.
  - mem_valid remains asserted at most until the edge after mem_data_ok.
- FSM RESP (one cycle):
  - resp_data_ok[g]=1, resp_data = captured data.
  - last pointer <= g; return to IDLE.
  - mem_data_ok-to-resp_data_ok latency = 1 cycle; minimum grant-to-grant spacing = request-to-mem_valid (1) + memory latency + 2.
- resp_data_ok is one-hot or zero, never multi-bit; resp_data holds its last value outside pulses.
- Abort: if req_valid[g] drops while in BUSY (fetch redirect), the downstream transaction still completes. In RESP, resp_data_ok[g] is suppressed (stays 0) and the pointer still advances.
- Simultaneous: a request arriving in the RESP cycle is arbitrated in the following IDLE cycle. A port whose valid is still high after its own data_ok is treated as a new request.
- Starvation bound: with both ports continuously requesting, grants strictly alternate 0,1,0,1.
- mem_data_ok while in IDLE or RESP is ignored (spurious); state is unaffected.
- Reset asserted mid-transaction: immediate return to IDLE, all outputs 0, and no data_ok is generated for the in-flight request.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined:
  - grant_cnt[i] increments on every resp_data_ok[i].
  - wait_cnt[i] increments on every cycle in which req_valid[i]=1 and port i is not the current grant holder.
  - Both counters wrap at 2^CNT_W and reset to 0.
- When undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Single read, port 0:
  - Stimulus: req_valid=01, addr 0x8000_0000, memory returns 0x13 after 3 cycles.
  - Response: mem_valid at t+1 with addr 0x8000_0000; resp_data_ok=01 with resp_data 0x13 exactly 1 cycle after mem_data_ok.
- Contention:
  - Stimulus: both ports valid continuously from reset for 4 transactions.
  - Response: grant order 0,1,0,1; mem_addr matches the granted port each time.
- Abort:
  - Stimulus: port 0 granted, req_valid[0] dropped 1 cycle after mem_valid rises.
  - Response: mem transaction completes, resp_data_ok stays 00, next grant goes to port 1 if pending.
- Write:
  - Stimulus: port 1 write, wdata 0xDEAD_BEEF, strobe 0x0F; port 1 changes wdata mid-BUSY.
  - Response: mem_wdata stays 0xDEAD_BEEF, mem_strobe 0x0F, then resp_data_ok=10.
- Reset mid-operation:
  - Stimulus: assert reset during BUSY.
  - Response: mem_valid=0 and resp_data_ok=00 immediately; after release, port 0 wins the first tie.
- With ARB_PERF_CNT_EN:
  - Stimulus: contention test above.
  - Response: grant_cnt = {2,2}; wait_cnt[1] equals the number of cycles port 1 was valid while port 0 held the grant.
